// File: rtl/an_scan_mux_pkg.sv
// sseg_pkg: shared seven-segment types and the hex-to-segment decode.
// Segment vectors are active-high, with bit 0 = a through bit 6 = g.
// Any display block that needs the glyph table imports this package.
package sseg_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_BLANK = 7'h00;

    function automatic seg_t hex_to_seg(input logic [3:0] hex);
        seg_t s;
        case (hex)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            4'hF: s = 7'h71;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/an_scan_mux_if.sv
// an_scan_mux_if: groups the signals between the datapath and the display scanner.
//   master : the datapath side. It drives en, digit_data, dp_in and blank_mask.
//   slave  : the scanner side. It drives an, seg, dp, digit_sel and tick.
interface an_scan_mux_if #(
    parameter int NUM_DIGITS = 4
);
    import sseg_pkg::*;

    localparam int SEL_W = $clog2(NUM_DIGITS);

    logic                      en;
    logic [4*NUM_DIGITS-1:0]   digit_data;
    logic [NUM_DIGITS-1:0]     dp_in;
    logic [NUM_DIGITS-1:0]     blank_mask;
    logic [NUM_DIGITS-1:0]     an;
    seg_t                      seg;
    logic                      dp;
    logic [SEL_W-1:0]          digit_sel;
    logic                      tick;

    modport master (
        output en, digit_data, dp_in, blank_mask,
        input  an, seg, dp, digit_sel, tick
    );

    modport slave (
        input  en, digit_data, dp_in, blank_mask,
        output an, seg, dp, digit_sel, tick
    );

endinterface

// File: rtl/an_scan_mux_hex_to_sseg.sv
// hex_to_sseg: combinational hex nibble to seven-segment decoder.
//   i_hex : 4-bit nibble
//   o_seg : active-high segments, bit 0 = a through bit 6 = g
module hex_to_sseg
    import sseg_pkg::*;
(
    input  logic [3:0] i_hex,
    output seg_t       o_seg
);

    assign o_seg = hex_to_seg(i_hex);

endmodule

// File: rtl/an_scan_mux.sv
// an_scan_mux: time-multiplexed seven-segment scanner.
//   clk, reset : system clock and synchronous active-high reset
//   bus.slave  : en, digit_data, dp_in, blank_mask (in);
//                an, seg, dp, digit_sel, tick (out, all registered)
// A prescaler of REFRESH_DIV cycles steps digit_sel through 0..NUM_DIGITS-1.
// Each advance blanks the anodes for one cycle so the previous digit's
// segments never light up the new digit.
module an_scan_mux
    import sseg_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int SEL_W       = $clog2(NUM_DIGITS),
    parameter int REFRESH_DIV = 100000,
    parameter int ACTIVE_LOW  = 1
) (
    input  logic         clk,
    input  logic         reset,
    an_scan_mux_if.slave bus
);

    localparam int   CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic POL   = (ACTIVE_LOW != 0);

    generate
        if (NUM_DIGITS < 2 || REFRESH_DIV < 2) begin : g_bad_param
            $error("an_scan_mux: NUM_DIGITS and REFRESH_DIV must both be >= 2");
        end
    endgenerate

    logic [CNT_W-1:0]      r_div_cnt;
    logic [SEL_W-1:0]      r_sel;
    logic                  r_tick;
    logic                  r_live;
    logic [NUM_DIGITS-1:0] r_an;
    seg_t                  r_seg;
    logic                  r_dp;

    logic                  w_adv;
    logic [SEL_W-1:0]      w_sel_nxt;
    logic [NUM_DIGITS-1:0] w_onehot;
    logic [NUM_DIGITS-1:0] w_an_raw;
    logic [3:0]            w_nib;
    seg_t                  w_seg;

    assign w_adv     = bus.en && (r_div_cnt == CNT_W'(REFRESH_DIV - 1));
    // Explicit wrap, so a non-power-of-two digit count never reaches NUM_DIGITS.
    assign w_sel_nxt = (r_sel == SEL_W'(NUM_DIGITS - 1)) ? '0 : r_sel + 1'b1;
    assign w_onehot  = NUM_DIGITS'(1) << r_sel;
    assign w_nib     = bus.digit_data[r_sel*4 +: 4];

    // Anodes stay dark in three cases:
    //   - on the advance edge (dead time);
    //   - on the first edge after reset, so digit 0 lights at the second edge;
    //   - for a blanked digit.
    assign w_an_raw  = (w_adv || !r_live || bus.blank_mask[r_sel]) ? '0 : w_onehot;

    hex_to_sseg u_dec (
        .i_hex (w_nib),
        .o_seg (w_seg)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_div_cnt <= '0;
            r_sel     <= '0;
            r_tick    <= 1'b0;
            r_live    <= 1'b0;
            r_an      <= {NUM_DIGITS{POL}};
            r_seg     <= SEG_BLANK ^ {7{POL}};
            r_dp      <= POL;
        end else begin
            r_live <= 1'b1;
            if (bus.en) begin
                r_div_cnt <= w_adv ? '0 : r_div_cnt + 1'b1;
            end
            if (w_adv) begin
                r_sel <= w_sel_nxt;
            end
            r_tick <= w_adv;
            r_an   <= w_an_raw ^ {NUM_DIGITS{POL}};
            // Segments follow the pre-edge selection, so they land together
            // with the new anode one cycle after the advance.
            r_seg  <= w_seg ^ {7{POL}};
            r_dp   <= bus.dp_in[r_sel] ^ POL;
        end
    end

    assign bus.an        = r_an;
    assign bus.seg       = r_seg;
    assign bus.dp        = r_dp;
    assign bus.digit_sel = r_sel;
    assign bus.tick      = r_tick;

endmodule

// File: tb/tb_an_scan_mux.sv
module tb_an_scan_mux;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    an_scan_mux_if #(.NUM_DIGITS(4)) bus4 ();
    an_scan_mux_if #(.NUM_DIGITS(3)) bus3 ();

    an_scan_mux #(.NUM_DIGITS(4), .REFRESH_DIV(4), .ACTIVE_LOW(1)) dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus4)
    );

    an_scan_mux #(.NUM_DIGITS(3), .REFRESH_DIV(4), .ACTIVE_LOW(0)) dut3 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus3)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Expected state of the 4-digit, active-low DUT after each edge.
    typedef struct {
        logic [1:0] sel;
        logic       tick;
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
    } vec_t;

    vec_t tbl[17];

    function automatic vec_t mk(logic [1:0] s, logic t, logic [3:0] a, logic [6:0] g, logic d);
        vec_t v;
        v.sel = s; v.tick = t; v.an = a; v.seg = g; v.dp = d;
        return v;
    endfunction

    task automatic chk4(input string tag, input vec_t e);
        chk({tag, ".sel"},  32'(bus4.digit_sel), 32'(e.sel));
        chk({tag, ".tick"}, 32'(bus4.tick),      32'(e.tick));
        chk({tag, ".an"},   32'(bus4.an),        32'(e.an));
        chk({tag, ".seg"},  32'(bus4.seg),       32'(e.seg));
        chk({tag, ".dp"},   32'(bus4.dp),        32'(e.dp));
    endtask

    initial begin
        // Patterns: 0 -> 40, 1 -> 79, 2 -> 24, 3 -> 30 (active-low).
        // blank_mask = 0100 keeps slot 2 dark; dp_in = 0001.
        tbl[0]  = mk(0, 0, 4'hF, 7'h40, 0);
        tbl[1]  = mk(0, 0, 4'hE, 7'h40, 0);
        tbl[2]  = mk(0, 0, 4'hE, 7'h40, 0);
        tbl[3]  = mk(1, 1, 4'hF, 7'h40, 0);
        tbl[4]  = mk(1, 0, 4'hD, 7'h79, 1);
        tbl[5]  = mk(1, 0, 4'hD, 7'h79, 1);
        tbl[6]  = mk(1, 0, 4'hD, 7'h79, 1);
        tbl[7]  = mk(2, 1, 4'hF, 7'h79, 1);
        tbl[8]  = mk(2, 0, 4'hF, 7'h24, 1);
        tbl[9]  = mk(2, 0, 4'hF, 7'h24, 1);
        tbl[10] = mk(2, 0, 4'hF, 7'h24, 1);
        tbl[11] = mk(3, 1, 4'hF, 7'h24, 1);
        tbl[12] = mk(3, 0, 4'h7, 7'h30, 1);
        tbl[13] = mk(3, 0, 4'h7, 7'h30, 1);
        tbl[14] = mk(3, 0, 4'h7, 7'h30, 1);
        tbl[15] = mk(0, 1, 4'hF, 7'h30, 1);
        tbl[16] = mk(0, 0, 4'hE, 7'h40, 0);

        reset           = 1'b1;
        bus4.en         = 1'b0;
        bus4.digit_data = 16'h3210;
        bus4.dp_in      = 4'b0001;
        bus4.blank_mask = 4'b0100;
        bus3.en         = 1'b0;
        bus3.digit_data = 12'h210;
        bus3.dp_in      = 3'b000;
        bus3.blank_mask = 3'b000;

        // Reset state, both polarities.
        for (int i = 0; i < 3; i++) step();
        chk4("rst", mk(0, 0, 4'hF, 7'h7F, 1));
        chk("rst3.an",  32'(bus3.an),  32'h0);
        chk("rst3.seg", 32'(bus3.seg), 32'h0);
        chk("rst3.dp",  32'(bus3.dp),  32'h0);

        // Full scan, with the 3-digit active-high DUT running alongside.
        reset   = 1'b0;
        bus4.en = 1'b1;
        bus3.en = 1'b1;
        for (int i = 0; i < 17; i++) begin
            step();
            chk4($sformatf("scan%0d", i + 1), tbl[i]);
            chk("scan3.sel_range", 32'(bus3.digit_sel < 2'd3), 32'h1);
            if ((i + 1) % 4 == 0)
                chk("scan3.tick", 32'(bus3.tick), 32'h1);
        end

        // Advance into slot 1, then freeze with div_cnt held at 1.
        step(); step();
        step(); chk4("adv1", mk(1, 1, 4'hF, 7'h40, 0));
        step(); chk4("slot1", mk(1, 0, 4'hD, 7'h79, 1));
        bus4.en = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (i == 10) bus4.digit_data = 16'h32A0;
            step();
            chk("frz.sel",  32'(bus4.digit_sel), 32'h1);
            chk("frz.tick", 32'(bus4.tick),      32'h0);
            chk("frz.an",   32'(bus4.an),        32'hD);
            chk("frz.seg",  32'(bus4.seg),       (i >= 10) ? 32'h08 : 32'h79);
        end
        // The advance lands REFRESH_DIV - 1 = 3 edges after re-enable.
        bus4.en = 1'b1;
        step(); chk4("ren1", mk(1, 0, 4'hD, 7'h08, 1));
        step(); chk4("ren2", mk(1, 0, 4'hD, 7'h08, 1));
        step(); chk4("ren3", mk(2, 1, 4'hF, 7'h08, 1));
        step(); chk4("slot2", mk(2, 0, 4'hF, 7'h24, 1));

        // Mid-scan reset during slot 2.
        reset = 1'b1;
        step(); chk4("mrst", mk(0, 0, 4'hF, 7'h7F, 1));
        reset = 1'b0;
        step(); chk4("rel1", mk(0, 0, 4'hF, 7'h40, 0));
        step(); chk4("rel2", mk(0, 0, 4'hE, 7'h40, 0));
        step(); chk4("rel3", mk(0, 0, 4'hE, 7'h40, 0));
        step(); chk4("rel4", mk(1, 1, 4'hF, 7'h40, 0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Three-digit DUT, checked mid-slot: digit_sel 0,1,2,0 with active-high
    // anodes and segments.
    initial begin
        logic [1:0] exp_sel [4];
        logic [2:0] exp_an  [4];
        logic [6:0] exp_seg [4];
        exp_sel[0] = 2'd0; exp_an[0] = 3'b001; exp_seg[0] = 7'h3F;
        exp_sel[1] = 2'd1; exp_an[1] = 3'b010; exp_seg[1] = 7'h06;
        exp_sel[2] = 2'd2; exp_an[2] = 3'b100; exp_seg[2] = 7'h5B;
        exp_sel[3] = 2'd0; exp_an[3] = 3'b001; exp_seg[3] = 7'h3F;
        // Wait out the 3 reset edges, then sample after edges 2, 6, 10 and 14
        // following the reset release.
        for (int i = 0; i < 3; i++) @(posedge clk);
        for (int k = 0; k < 4; k++) begin
            repeat ((k == 0) ? 2 : 4) @(posedge clk);
            @(negedge clk);
            chk($sformatf("d3.sel%0d", k), 32'(bus3.digit_sel), 32'(exp_sel[k]));
            chk($sformatf("d3.an%0d",  k), 32'(bus3.an),        32'(exp_an[k]));
            chk($sformatf("d3.seg%0d", k), 32'(bus3.seg),       32'(exp_seg[k]));
        end
    end

endmodule

// File: doc/an_scan_mux.md
Name: an_scan_mux

Overview:
Parametrised seven-segment display scanner. Replaces the fixed 2-to-4 anode decoder with a time-multiplexed driver: a refresh prescaler steps a digit selector across NUM_DIGITS positions. For each selected digit the block drives one anode, the decoded segments of that digit's hex nibble, and its decimal point. Sits between the datapath registers and the board display pins.

Parameters:
NUM_DIGITS, 4, number of display digits (>=2; need not be a power of 2)
SEL_W, $clog2(NUM_DIGITS), digit select width (derived; do not override)
REFRESH_DIV, 100000, clk cycles per digit slot (>=2); 100 MHz gives 1 kHz per digit
ACTIVE_LOW, 1, 1 = an/seg/dp pins active-low; 0 = active-high

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
en  input  1  scan enable; 0 freezes the scan position
digit_data  input  4*NUM_DIGITS  hex nibble per digit; digit k = [4k+3:4k]
dp_in  input  NUM_DIGITS  decimal point request per digit, active-high
blank_mask  input  NUM_DIGITS  1 = digit k dark (anode never asserted)
an  output  NUM_DIGITS  anode drive, one-hot asserted, polarity per ACTIVE_LOW
seg  output  7  segments, seg[0]=a .. seg[6]=g, polarity per ACTIVE_LOW
dp  output  1  decimal point pin, polarity per ACTIVE_LOW
digit_sel  output  SEL_W  current scan position
tick  output  1  one-cycle pulse at each digit advance

Behaviour:
- One clock, synchronous active-high reset. All outputs are registered.
- Reset values: div_cnt=0, digit_sel=0, tick=0. an, seg and dp are all inactive: all-ones when ACTIVE_LOW=1, all-zeros when ACTIVE_LOW=0. Reset asserted mid-scan takes effect at the next edge with no partial state.
- Prescaler: while en=1, div_cnt counts 0..REFRESH_DIV-1 and wraps to 0.
- Advance: in a cycle with en=1 and div_cnt==REFRESH_DIV-1, the next edge sets digit_sel to digit_sel+1, wrapping NUM_DIGITS-1 -> 0. The same edge sets tick=1 for exactly one cycle.
- en=0: div_cnt and digit_sel hold, tick=0. Outputs keep showing the current digit and track data changes.
- Dead time: the edge that advances digit_sel also drives an to all-inactive for one cycle (anti-ghosting). The following edge asserts the new digit's anode.
- Segments: seg and dp are registered from the current (pre-edge) digit_sel. They show the new digit one cycle after the advance, aligned with the anode.
- Anode: an = onehot(digit_sel). If blank_mask[digit_sel]=1, an is all-inactive; seg and dp still update.
- Latency: changes on digit_data, dp_in or blank_mask for the selected digit appear on the pins 1 cycle later. After reset is released, digit 0 is displayed at the second edge.
- Decode, active-high form, gfedcba:
  0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71
- ACTIVE_LOW=1 inverts an, seg and dp at the output register. digit_sel and tick are never inverted.
- Invalid parameters (NUM_DIGITS<2 or REFRESH_DIV<2) raise an elaboration-time $error.

Decomposition:
- Package sseg_pkg:
  - typedef seg_t (logic [6:0])
  - constant SEG_BLANK = 7'h00
  - function hex_to_seg(logic [3:0]) returning seg_t, table as above
- Sub-module hex_to_sseg: purely combinational wrapper of hex_to_seg, for reuse by other display blocks.
- an_scan_mux holds the prescaler, selector, blanking and output registers.

Test Plan:
- Reset/polarity: ACTIVE_LOW=1, hold reset 3 cycles -> an=4'b1111, seg=7'h7F, dp=1, digit_sel=0, tick=0. Release -> at 2nd edge an=4'b1110 and seg=~hex_to_seg(digit_data[3:0]).
- Full scan: REFRESH_DIV=4, NUM_DIGITS=4, digit_data=16'h3210, en=1 -> digit_sel 0,1,2,3,0 every 4 cycles. tick is high one cycle each step, and an is 4'b1111 for exactly 1 cycle after each tick. Observed seg sequence: ~3F, ~06, ~5B, ~4F.
- Non-power-of-2 wrap: NUM_DIGITS=3 -> digit_sel sequence 0,1,2,0; it never reaches 3. an cycles 110,101,011.
- Blank/dp: blank_mask=4'b0100, dp_in=4'b0001 -> no assertion of an[2] during slot 2. dp=0 (asserted) only during slot 0.
- Freeze: deassert en during slot 1 for 20 cycles -> digit_sel stays 1, tick=0, an=4'b1101. Change digit_data[7:4] to 4'hA -> seg=~77 one cycle later. Re-enable -> the advance occurs REFRESH_DIV-k cycles later, where k is the held div_cnt.
- Mid-scan reset: assert reset during slot 2 -> next edge all reset values. Scan restarts at digit 0 with div_cnt=0.
